// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, result payload.
package mdu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } state_e;

  // Captured result, laid out as {hi, lo}.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU: 32x32 products and 32/32 divisions.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]     i_op,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_res,
  output logic                o_div_zero
);

  logic [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0] w_prod_u;
  logic                w_b_zero;
  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [DATA_W-1:0]   w_bs_safe;
  logic [DATA_W-1:0]   w_bu_safe;
  logic [DATA_W-1:0]   w_q_mag;
  logic [DATA_W-1:0]   w_r_mag;
  logic [DATA_W-1:0]   w_sq;
  logic [DATA_W-1:0]   w_sr;
  logic [DATA_W-1:0]   w_uq;
  logic [DATA_W-1:0]   w_ur;

  // Low 64 bits of the sign/zero-extended product are the exact 64-bit result.
  assign w_prod_s = {{DATA_W{i_a[DATA_W-1]}}, i_a} * {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // Signed divide done on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
  assign w_b_zero  = (i_b == '0);
  assign w_a_mag   = i_a[DATA_W-1] ? -i_a : i_a;
  assign w_b_mag   = i_b[DATA_W-1] ? -i_b : i_b;
  assign w_bs_safe = w_b_zero ? DATA_W'(1) : w_b_mag;
  assign w_bu_safe = w_b_zero ? DATA_W'(1) : i_b;
  assign w_q_mag   = w_a_mag / w_bs_safe;
  assign w_r_mag   = w_a_mag % w_bs_safe;
  assign w_sq      = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) ? -w_q_mag : w_q_mag;
  assign w_sr      = i_a[DATA_W-1] ? -w_r_mag : w_r_mag;
  assign w_uq      = i_a / w_bu_safe;
  assign w_ur      = i_a % w_bu_safe;

  // Select the {hi, lo} result for the requested op.
  always_comb begin
    o_res      = '0;
    o_div_zero = 1'b0;
    case (i_op)
      OP_MULT:  o_res = w_prod_s;
      OP_MULTU: o_res = w_prod_u;
      OP_DIV: begin
        o_res      = {w_sr, w_sq};
        o_div_zero = w_b_zero;
      end
      OP_DIVU: begin
        o_res      = {w_ur, w_uq};
        o_div_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV sequencing plus HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DATA_W-1:0]   r_hi, w_hi_nxt;
  logic [DATA_W-1:0]   r_lo, w_lo_nxt;
  hilo_t               r_res, w_res_nxt;
  logic                r_dz, w_dz_nxt;
  logic [2*DATA_W-1:0] w_calc_res;
  logic                w_calc_dz;

  mdu_calc u_calc (
    .i_op       (op),
    .i_a        (A),
    .i_b        (B),
    .o_res      (w_calc_res),
    .o_div_zero (w_calc_dz)
  );

  // State, counter, captured result and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_res   <= w_res_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  // Issue decode in IDLE; count down while running and commit on the last busy cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_res_nxt   = r_res;
    w_dz_nxt    = r_dz;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_res_nxt   = hilo_t'(w_calc_res);
              w_dz_nxt    = 1'b0;
              w_cnt_nxt   = CNT_W'(MUL_CYCLES);
              w_busy_nxt  = 1'b1;
              w_state_nxt = ST_MUL_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_res_nxt   = hilo_t'(w_calc_res);
              w_dz_nxt    = w_calc_dz;
              w_cnt_nxt   = CNT_W'(DIV_CYCLES);
              w_busy_nxt  = 1'b1;
              w_state_nxt = ST_DIV_RUN;
            end
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: ;
          endcase
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          // A divide by zero completes without touching HI/LO.
          if (!r_dz) begin
            w_hi_nxt = r_res.hi;
            w_lo_nxt = r_res.lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;
  // Move-from path is purely a read mux on the current op.
  assign out  = (op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: random and directed ops against an arithmetic reference.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op    = 4'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo),
    .out   (out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // Architectural effect of one op on HI/LO, using 64-bit integer arithmetic.
  task automatic ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                           output logic [31:0] nhi, output logic [31:0] nlo);
    longint          sx, sy, p, r;
    longint unsigned ux, uy, pu;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    nhi = cur_hi;
    nlo = cur_lo;
    case (o)
      OP_MULT: begin
        p = sx * sy;
        nhi = p[63:32];
        nlo = p[31:0];
      end
      OP_MULTU: begin
        pu = ux * uy;
        nhi = pu[63:32];
        nlo = pu[31:0];
      end
      OP_DIV: if (y != 32'd0) begin
        p = sx / sy;
        r = sx % sy;
        nlo = p[31:0];
        nhi = r[31:0];
      end
      OP_DIVU: if (y != 32'd0) begin
        nlo = x / y;
        nhi = x % y;
      end
      OP_MTHI: nhi = x;
      OP_MTLO: nlo = x;
      default: ;
    endcase
  endtask

  // Drive one start; long ops are handed to the monitor, short ops checked next cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name);
    exp_t        e;
    logic [31:0] nh, nl;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    ref_model(o, x, y, m_hi, m_lo, nh, nl);
    if (is_long(o)) begin
      e.hi = nh; e.lo = nl; e.old_hi = m_hi; e.old_lo = m_lo; e.name = name;
      e.cycles = ((o == OP_MULT) || (o == OP_MULTU)) ? int'(MUL_N) : int'(DIV_N);
      sb_q.push_back(e);
    end
    m_hi = nh;
    m_lo = nl;
    @(negedge clk);
    start = 1'b0; op = OP_NONE; a = $urandom; b = $urandom;
    if (is_long(o)) begin
      chk({name, " busy rise"}, 32'(busy), 32'd1);
    end else begin
      chk({name, " busy"}, 32'(busy), 32'd0);
      chk({name, " HI"}, hi, m_hi);
      chk({name, " LO"}, lo, m_lo);
    end
  endtask

  // Wait for busy to drop; junk 1 = random starts while busy, 2 = MTLO 0xAA while busy.
  task automatic wait_idle(input int junk);
    int n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (junk == 1) begin
        start = ($urandom_range(0, 2) == 0);
        op = 4'($urandom_range(0, 8));
        a = $urandom; b = $urandom;
      end else if (junk == 2) begin
        start = 1'b1; op = OP_MTLO; a = 32'h0000_00AA;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; op = OP_NONE;
    if (n >= 64) chk("wait_idle timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_out();
    @(negedge clk);
    start = 1'b0;
    op = OP_MFHI; #1 chk("out MFHI", out, m_hi);
    op = OP_MFLO; #1 chk("out MFLO", out, m_lo);
    op = OP_MULT; #1 chk("out other op", out, m_lo);
    op = OP_NONE;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    start = 1'b0; op = OP_NONE;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset HI", hi, 32'd0);
    chk("reset LO", lo, 32'd0);
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: HI/LO must hold while busy; at busy fall compare result and busy length.
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected busy: got busy=1 expected 0");
        end else begin
          chk({sb_q[0].name, " hold HI"}, hi, sb_q[0].old_hi);
          chk({sb_q[0].name, " hold LO"}, lo, sb_q[0].old_lo);
        end
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy fall with empty scoreboard: got 1 entry short expected 0");
        end else begin
          e = sb_q.pop_front();
          chk({e.name, " HI"}, hi, e.hi);
          chk({e.name, " LO"}, lo, e.lo);
          chk({e.name, " busy cycles"}, 32'(busy_cnt), 32'(e.cycles));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] rx, ry;
    #2;
    chk("por busy", 32'(busy), 32'd0);
    chk("por HI", hi, 32'd0);
    chk("por LO", lo, 32'd0);

    // First start accepted on the first rising edge after reset release.
    @(posedge clk);
    #2 rst = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hCAFE_F00D;
    m_hi = 32'hCAFE_F00D;
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
    chk("first start MTHI", hi, 32'hCAFE_F00D);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
    wait_idle(0);
    chk("mult -2*3 HI lit", hi, 32'hFFFF_FFFF);
    chk("mult -2*3 LO lit", lo, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
    wait_idle(1);
    chk("multu max HI lit", hi, 32'hFFFF_FFFE);
    chk("multu max LO lit", lo, 32'h0000_0001);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    wait_idle(0);
    chk("div -7/2 LO lit", lo, 32'hFFFF_FFFD);
    chk("div -7/2 HI lit", hi, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    wait_idle(1);
    chk("div ovf LO lit", lo, 32'h8000_0000);
    chk("div ovf HI lit", hi, 32'h0000_0000);

    issue(OP_MTHI, 32'h1234_5678, 32'd0, "mthi");
    issue(OP_DIVU, 32'h0000_0040, 32'd0, "divu by 0");
    wait_idle(0);
    chk("divu by 0 HI lit", hi, 32'h1234_5678);
    check_out();

    issue(OP_DIVU, 32'd1000, 32'd7, "divu mtlo-while-busy");
    wait_idle(2);
    chk("divu 1000/7 LO lit", lo, 32'd142);
    chk("divu 1000/7 HI lit", hi, 32'd6);

    // Abort a divide in its fourth busy cycle.
    issue(OP_DIV, 32'h7FFF_0000, 32'd3, "div aborted");
    repeat (3) @(negedge clk);
    do_reset();
    repeat (15) @(negedge clk);
    chk("post-abort busy", 32'(busy), 32'd0);
    chk("post-abort HI", hi, 32'd0);
    chk("post-abort LO", lo, 32'd0);

    for (int i = 0; i < 80; i++) begin
      ro = 4'($urandom_range(0, 8));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 5) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) ry = 32'hFFFF_FFFF;
      issue(ro, rx, ry, "rand");
      wait_idle(int'($urandom_range(0, 1)));
      if ((i % 10) == 9) check_out();
    end

    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
